// File: rtl/ram_arbiter.sv
// Two-master arbiter/controller for a dual-address RAM with combinational read.
// Serves one read and one write per cycle when addresses differ, serializes
// same-address collisions, and optionally zero-fills the RAM after reset.
module ram_arbiter #(
  parameter int unsigned MEM_WIDTH      = 8,
  parameter int unsigned WORD_SIZE      = 4,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // master 0
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [WORD_SIZE-1:0] m0_addr,
  input  logic [MEM_WIDTH-1:0] m0_wdata,
  output logic                 m0_gnt,
  output logic                 m0_rvalid,
  output logic [MEM_WIDTH-1:0] m0_rdata,
  // master 1
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [WORD_SIZE-1:0] m1_addr,
  input  logic [MEM_WIDTH-1:0] m1_wdata,
  output logic                 m1_gnt,
  output logic                 m1_rvalid,
  output logic [MEM_WIDTH-1:0] m1_rdata,
  // RAM side
  output logic                 ram_wr_en,
  output logic [WORD_SIZE-1:0] ram_wr_addr,
  output logic [MEM_WIDTH-1:0] ram_wdata,
  output logic [WORD_SIZE-1:0] ram_rd_addr,
  input  logic [MEM_WIDTH-1:0] ram_rdata,
  output logic                 init_done
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  localparam state_e RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

  state_e                 state_q, state_d;
  logic [WORD_SIZE-1:0]   clr_cnt_q, clr_cnt_d;
  logic                   rr_q, rr_d;          // 0: m0 favoured on same-type contention
  logic                   rd_def_q, rd_def_d;  // a colliding read was deferred last cycle
  logic                   init_done_q;
  logic                   m0_rvalid_q, m1_rvalid_q;
  logic [MEM_WIDTH-1:0]   m0_rdata_q, m1_rdata_q;

  logic                   gnt0, gnt1;
  logic                   rd0, rd1;

  // Arbitration, clear sequencing and RAM port muxing; all gated by rst_n so
  // grants and RAM strobes drop the moment reset asserts.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    rr_d        = rr_q;
    rd_def_d    = 1'b0;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    rd0         = 1'b0;
    rd1         = 1'b0;
    ram_wr_en   = 1'b0;
    ram_wr_addr = '0;
    ram_wdata   = '0;
    ram_rd_addr = '0;

    if (rst_n) begin
      unique case (state_q)
        ST_INIT: begin
          ram_wr_en   = 1'b1;
          ram_wr_addr = clr_cnt_q;
          clr_cnt_d   = clr_cnt_q + WORD_SIZE'(1);
          if (clr_cnt_q == '1) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (m0_req && !m1_req) begin
            gnt0 = 1'b1;
          end else if (m1_req && !m0_req) begin
            gnt1 = 1'b1;
          end else if (m0_req && m1_req) begin
            if (m0_we == m1_we) begin
              gnt0 = !rr_q;
              gnt1 = rr_q;
              rr_d = !rr_q;
            end else if (m0_addr != m1_addr) begin
              gnt0 = 1'b1;
              gnt1 = 1'b1;
            end else if (rd_def_q) begin
              // read already waited once: it wins, sees pre-write data
              gnt0 = !m0_we;
              gnt1 = !m1_we;
            end else begin
              // writer first so the following read returns the new data
              gnt0     = m0_we;
              gnt1     = m1_we;
              rd_def_d = 1'b1;
            end
          end

          rd0 = gnt0 && !m0_we;
          rd1 = gnt1 && !m1_we;

          if (gnt0 && m0_we) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = m0_addr;
            ram_wdata   = m0_wdata;
          end else if (gnt1 && m1_we) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = m1_addr;
            ram_wdata   = m1_wdata;
          end

          if (rd0)      ram_rd_addr = m0_addr;
          else if (rd1) ram_rd_addr = m1_addr;
        end
        default: ;
      endcase
    end
  end

  // State, arbitration memory and registered read returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      clr_cnt_q   <= '0;
      rr_q        <= 1'b0;
      rd_def_q    <= 1'b0;
      init_done_q <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rr_q        <= rr_d;
      rd_def_q    <= rd_def_d;
      init_done_q <= (state_d == ST_RUN);
      m0_rvalid_q <= rd0;
      m1_rvalid_q <= rd1;
      if (rd0) m0_rdata_q <= ram_rdata;
      if (rd1) m1_rdata_q <= ram_rdata;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural dual-address RAM attached.
module tb_ram_arbiter;

  localparam int unsigned MW = 8;
  localparam int unsigned WS = 4;

  logic          clk;
  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [WS-1:0] m0_addr, m1_addr;
  logic [MW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [MW-1:0] m0_rdata, m1_rdata;
  logic          ram_wr_en;
  logic [WS-1:0] ram_wr_addr, ram_rd_addr;
  logic [MW-1:0] ram_wdata, ram_rdata;
  logic          init_done;

  logic [MW-1:0] mem [16];

  int n_chk = 0;
  int n_err = 0;

  ram_arbiter #(.MEM_WIDTH(MW), .WORD_SIZE(WS), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wdata(ram_wdata),
    .ram_rd_addr(ram_rd_addr), .ram_rdata(ram_rdata), .init_done(init_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: write at the clock edge, combinational read.
  always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_wdata;
  assign ram_rdata = mem[ram_rd_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m0_set(input logic req, input logic we, input logic [WS-1:0] a, input logic [MW-1:0] d);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic m1_set(input logic req, input logic we, input logic [WS-1:0] a, input logic [MW-1:0] d);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
  endtask

  // Starts and ends at a falling edge; single-master read with data check.
  task automatic m0_read(input logic [WS-1:0] a, input logic [MW-1:0] exp);
    m0_set(1'b1, 1'b0, a, 8'h00);
    #1 check("m0_rd_gnt", 32'(m0_gnt), 32'd1);
    @(negedge clk);
    m0_set(1'b0, 1'b0, 4'h0, 8'h00);
    check("m0_rd_rvalid", 32'(m0_rvalid), 32'd1);
    check("m0_rd_data", 32'(m0_rdata), 32'(exp));
  endtask

  // Releases reset at a falling edge and verifies the clear sequence length.
  task automatic wait_init(input string tag);
    int cycles;
    cycles = 0;
    rst_n = 1'b1;
    while (!init_done && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        check({tag, "_gnt_in_init"}, 32'(m0_gnt), 32'd0);
        check({tag, "_clr_wr_en"}, 32'(ram_wr_en), 32'd1);
        check({tag, "_clr_addr"}, 32'(ram_wr_addr), 32'd1);
      end
      if (cycles == 15) check({tag, "_done_early"}, 32'(init_done), 32'd0);
    end
    check({tag, "_init_cycles"}, 32'(cycles), 32'd16);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'hFF;
    rst_n = 1'b0;
    m0_set(1'b0, 1'b0, 4'h0, 8'h00);
    m1_set(1'b0, 1'b0, 4'h0, 8'h00);
    repeat (2) @(negedge clk);

    // Reset state with a request pending
    m0_set(1'b1, 1'b0, 4'h0, 8'h00);
    #1;
    check("rst_gnt", 32'(m0_gnt), 32'd0);
    check("rst_wr_en", 32'(ram_wr_en), 32'd0);
    check("rst_done", 32'(init_done), 32'd0);
    @(negedge clk);

    // 1: clear after reset, every word reads 0
    wait_init("t1");
    m0_set(1'b0, 1'b0, 4'h0, 8'h00);
    for (int i = 0; i < 16; i++) m0_read(WS'(i), 8'h00);

    // 2: write then read-after-write from the other master
    m0_set(1'b1, 1'b1, 4'd3, 8'h5A);
    #1 check("t2_m0_gnt", 32'(m0_gnt), 32'd1);
    check("t2_wr_en", 32'(ram_wr_en), 32'd1);
    @(negedge clk);
    m0_set(1'b0, 1'b0, 4'h0, 8'h00);
    m1_set(1'b1, 1'b0, 4'd3, 8'h00);
    #1 check("t2_m1_gnt", 32'(m1_gnt), 32'd1);
    @(negedge clk);
    m1_set(1'b0, 1'b0, 4'h0, 8'h00);
    check("t2_m1_rvalid", 32'(m1_rvalid), 32'd1);
    check("t2_m1_rdata", 32'(m1_rdata), 32'h5A);

    // 3: two readers contend, round-robin alternation
    m0_set(1'b1, 1'b0, 4'd1, 8'h00);
    m1_set(1'b1, 1'b0, 4'd2, 8'h00);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_m0_gnt", 32'(m0_gnt), 32'(i % 2 == 0));
      check("t3_m1_gnt", 32'(m1_gnt), 32'(i % 2 == 1));
      @(negedge clk);
      check("t3_m0_rvalid", 32'(m0_rvalid), 32'(i % 2 == 0));
      check("t3_m1_rvalid", 32'(m1_rvalid), 32'(i % 2 == 1));
    end
    m0_set(1'b0, 1'b0, 4'h0, 8'h00);
    m1_set(1'b0, 1'b0, 4'h0, 8'h00);
    check("t3_m1_rdata", 32'(m1_rdata), 32'h00);

    // 4: concurrent write and read to different addresses
    m0_set(1'b1, 1'b1, 4'd7, 8'h11);
    m1_set(1'b1, 1'b0, 4'd9, 8'h00);
    #1;
    check("t4_m0_gnt", 32'(m0_gnt), 32'd1);
    check("t4_m1_gnt", 32'(m1_gnt), 32'd1);
    check("t4_rd_addr", 32'(ram_rd_addr), 32'd9);
    check("t4_wr_addr", 32'(ram_wr_addr), 32'd7);
    @(negedge clk);
    m0_set(1'b0, 1'b0, 4'h0, 8'h00);
    m1_set(1'b0, 1'b0, 4'h0, 8'h00);
    check("t4_m1_rvalid", 32'(m1_rvalid), 32'd1);
    check("t4_m1_rdata", 32'(m1_rdata), 32'h00);
    m0_read(4'd7, 8'h11);

    // 5: same-address collision, write first then read sees new data
    m0_set(1'b1, 1'b1, 4'd5, 8'h22);
    m1_set(1'b1, 1'b0, 4'd5, 8'h00);
    #1;
    check("t5_m0_gnt", 32'(m0_gnt), 32'd1);
    check("t5_m1_gnt", 32'(m1_gnt), 32'd0);
    @(negedge clk);
    m0_set(1'b0, 1'b0, 4'h0, 8'h00);
    #1 check("t5_m1_gnt_late", 32'(m1_gnt), 32'd1);
    @(negedge clk);
    m1_set(1'b0, 1'b0, 4'h0, 8'h00);
    check("t5_m1_rvalid", 32'(m1_rvalid), 32'd1);
    check("t5_m1_rdata", 32'(m1_rdata), 32'h22);

    // 5b: writer keeps hammering; reader still wins on its second cycle
    m0_set(1'b1, 1'b1, 4'd5, 8'h33);
    m1_set(1'b1, 1'b0, 4'd5, 8'h00);
    #1;
    check("t5b_c0_m0_gnt", 32'(m0_gnt), 32'd1);
    check("t5b_c0_m1_gnt", 32'(m1_gnt), 32'd0);
    @(negedge clk);
    m0_set(1'b1, 1'b1, 4'd5, 8'h44);
    #1;
    check("t5b_c1_m0_gnt", 32'(m0_gnt), 32'd0);
    check("t5b_c1_m1_gnt", 32'(m1_gnt), 32'd1);
    check("t5b_c1_wr_en", 32'(ram_wr_en), 32'd0);
    @(negedge clk);
    m0_set(1'b0, 1'b0, 4'h0, 8'h00);
    m1_set(1'b0, 1'b0, 4'h0, 8'h00);
    check("t5b_m1_rvalid", 32'(m1_rvalid), 32'd1);
    check("t5b_m1_rdata", 32'(m1_rdata), 32'h33);

    // 6: reset lands on a granted read; pulse lost, clear restarts
    m1_set(1'b1, 1'b0, 4'd3, 8'h00);
    #1 check("t6_m1_gnt", 32'(m1_gnt), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("t6_gnt_drop", 32'(m1_gnt), 32'd0);
    check("t6_wr_en", 32'(ram_wr_en), 32'd0);
    check("t6_done", 32'(init_done), 32'd0);
    @(negedge clk);
    m1_set(1'b0, 1'b0, 4'h0, 8'h00);
    check("t6_no_rvalid", 32'(m1_rvalid), 32'd0);
    wait_init("t6");
    check("t6_no_rvalid_after", 32'(m1_rvalid), 32'd0);
    m0_read(4'd3, 8'h00);
    m0_read(4'd7, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
